// File: rtl/pwm_meas.sv
// PWM width/period measurement block with a small register interface.
// Captures {period, width} in prescaled ticks between successive start edges.
module pwm_meas #(
    parameter int unsigned SYNC_STAGES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  sel_i,
    input  logic        we_i,
    input  logic [7:0]  raddr_i,
    input  logic        rd_i,
    output logic [31:0] data_o,
    input  logic        pwm_i,
    output logic        irq_meas
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ACT   = 2'd2,
        S_INACT = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   en_q, en_d, pol_q, pol_d, oneshot_q, oneshot_d, irq_en_q, irq_en_d;
    logic [15:0]            div_q, div_d, tmo_lim_q, tmo_lim_d;
    logic [15:0]            cnt_q, cnt_d, div_cnt_q, div_cnt_d, pend_q, pend_d;
    logic [31:0]            result_q, result_d, data_q, data_d;
    logic                   valid_q, valid_d, ovr_q, ovr_d, tmo_q, tmo_d;
    logic                   irq_q, irq_d;
    logic                   set_valid, set_tmo;
    logic                   wr_ctrl, wr_stat, wr_tmo;
    logic                   act_cur, act_prev, start_e, end_e, tick;
    logic [15:0]            cnt_inc, meas;
    logic                   unused_sel;

    assign unused_sel = ^sel_i;

    assign wr_ctrl = we_i && (waddr_i == 8'h00);
    assign wr_stat = we_i && (waddr_i == 8'h04);
    assign wr_tmo  = we_i && (waddr_i == 8'h0C);

    // The older of the last two synchronizer stages acts as the previous sample.
    assign act_cur  = sync_q[SYNC_STAGES-2] ^ pol_q;
    assign act_prev = sync_q[SYNC_STAGES-1] ^ pol_q;
    assign start_e  = act_cur & ~act_prev;
    assign end_e    = ~act_cur & act_prev;

    assign tick    = (state_q != S_IDLE) && (div_cnt_q >= div_q);
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign meas    = tick ? cnt_inc : cnt_q;

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        pol_d     = pol_q;
        oneshot_d = oneshot_q;
        irq_en_d  = irq_en_q;
        div_d     = div_q;
        tmo_lim_d = tmo_lim_q;
        cnt_d     = cnt_q;
        div_cnt_d = div_cnt_q;
        pend_d    = pend_q;
        result_d  = result_q;
        set_valid = 1'b0;
        set_tmo   = 1'b0;

        if (state_q != S_IDLE) begin
            if (tick) begin
                div_cnt_d = '0;
                cnt_d     = cnt_inc;
            end else begin
                div_cnt_d = div_cnt_q + 16'd1;
            end
        end

        case (state_q)
            S_IDLE: if (en_q) state_d = S_WAIT;
            S_WAIT: begin
                if (start_e) begin
                    state_d   = S_ACT;
                    cnt_d     = '0;
                    div_cnt_d = '0;
                end
            end
            S_ACT: begin
                if (cnt_q >= tmo_lim_q) begin
                    set_tmo = 1'b1;
                    state_d = S_WAIT;
                end else if (end_e) begin
                    pend_d  = meas;
                    state_d = S_INACT;
                end
            end
            S_INACT: begin
                if (cnt_q >= tmo_lim_q) begin
                    set_tmo = 1'b1;
                    state_d = S_WAIT;
                end else if (start_e) begin
                    result_d  = {meas, pend_q};
                    set_valid = 1'b1;
                    cnt_d     = '0;
                    div_cnt_d = '0;
                    if (oneshot_q) begin
                        en_d    = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ACT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A disabling CTRL write overrides any measurement event in the same cycle.
        if (wr_ctrl) begin
            en_d      = data_i[0];
            pol_d     = data_i[1];
            oneshot_d = data_i[2];
            irq_en_d  = data_i[3];
            div_d     = data_i[31:16];
            if (!data_i[0]) begin
                state_d   = S_IDLE;
                cnt_d     = '0;
                div_cnt_d = '0;
                pend_d    = '0;
                result_d  = result_q;
                set_valid = 1'b0;
                set_tmo   = 1'b0;
            end
        end
        if (wr_tmo) tmo_lim_d = data_i[15:0];

        valid_d = (valid_q & ~(wr_stat & data_i[0])) | set_valid;
        ovr_d   = (ovr_q   & ~(wr_stat & data_i[1])) | (set_valid & valid_q);
        tmo_d   = (tmo_q   & ~(wr_stat & data_i[2])) | set_tmo;
        irq_d   = irq_en_q & (set_valid | set_tmo);

        data_d = data_q;
        if (rd_i) begin
            case (raddr_i)
                8'h00:   data_d = {div_q, 12'd0, irq_en_q, oneshot_q, pol_q, en_q};
                8'h04:   data_d = {27'd0, state_q, tmo_q, ovr_q, valid_q};
                8'h08:   data_d = result_q;
                8'h0C:   data_d = {16'd0, tmo_lim_q};
                default: data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sync_q    <= '0;
            en_q      <= 1'b0;
            pol_q     <= 1'b0;
            oneshot_q <= 1'b0;
            irq_en_q  <= 1'b0;
            div_q     <= '0;
            tmo_lim_q <= '1;
            cnt_q     <= '0;
            div_cnt_q <= '0;
            pend_q    <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
            tmo_q     <= 1'b0;
            irq_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pwm_i};
            en_q      <= en_d;
            pol_q     <= pol_d;
            oneshot_q <= oneshot_d;
            irq_en_q  <= irq_en_d;
            div_q     <= div_d;
            tmo_lim_q <= tmo_lim_d;
            cnt_q     <= cnt_d;
            div_cnt_q <= div_cnt_d;
            pend_q    <= pend_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
            tmo_q     <= tmo_d;
            irq_q     <= irq_d;
            data_q    <= data_d;
        end
    end

    assign data_o   = data_q;
    assign irq_meas = irq_q;

endmodule

// File: tb/tb_pwm_meas.sv
// Scoreboard bench for pwm_meas: expected read data is queued when a read is
// issued and compared when the registered read data appears.
module tb_pwm_meas;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  waddr_i = '0;
    logic [31:0] data_i = '0;
    logic [3:0]  sel_i = '1;
    logic        we_i = 1'b0;
    logic [7:0]  raddr_i = '0;
    logic        rd_i = 1'b0;
    logic [31:0] data_o;
    logic        pwm_i = 1'b0;
    logic        irq_meas;

    localparam logic [7:0] A_CTRL = 8'h00, A_STAT = 8'h04, A_RES = 8'h08, A_TMO = 8'h0C;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned irq_cnt = 0;
    int unsigned irq_base = 0;
    logic        rd_pend = 1'b0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    pwm_meas #(.SYNC_STAGES(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .waddr_i(waddr_i), .data_i(data_i), .sel_i(sel_i), .we_i(we_i),
        .raddr_i(raddr_i), .rd_i(rd_i), .data_o(data_o),
        .pwm_i(pwm_i), .irq_meas(irq_meas)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    always @(posedge clk) rd_pend <= rd_i;

    always @(negedge clk) begin
        if (irq_meas) irq_cnt++;
        if (rd_pend) begin
            if (exp_q.size() == 0) check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
            else check_eq(tag_q.pop_front(), data_o, exp_q.pop_front());
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        waddr_i = a; data_i = d; we_i = 1'b1;
        cyc(1);
        we_i = 1'b0;
    endtask

    task automatic bus_rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
        raddr_i = a; rd_i = 1'b1;
        cyc(1);
        rd_i = 1'b0;
    endtask

    task automatic pwm_hl(input int h, input int l);
        pwm_i = 1'b1; cyc(h);
        pwm_i = 1'b0; cyc(l);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        #23 rst_n = 1'b1;
        cyc(2);

        bus_rd(A_CTRL, 32'h0000_0000, "rst_ctrl");
        bus_rd(A_STAT, 32'h0000_0000, "rst_stat");
        bus_rd(A_RES,  32'h0000_0000, "rst_result");
        bus_rd(A_TMO,  32'h0000_FFFF, "rst_tmo");
        bus_rd(8'h10,  32'h0000_0000, "unmapped_rd");
        cyc(1);
        check_eq("rst_irq", irq_cnt, 32'd0);

        // div=0: 3 high / 5 low, then a 6-high / 5-low period to force overrun
        bus_wr(A_CTRL, 32'h0000_0009);
        cyc(2);
        bus_rd(A_STAT, 32'h0000_0008, "A_wait_state");
        pwm_hl(3, 5);
        pwm_i = 1'b1; cyc(4);
        bus_rd(A_RES,  32'h0008_0003, "A_result");
        bus_rd(A_STAT, 32'h0000_0011, "A_stat_valid_act");
        pwm_i = 1'b0; cyc(5);
        pwm_i = 1'b1; cyc(4);
        bus_rd(A_STAT, 32'h0000_0013, "A_overrun");
        bus_rd(A_RES,  32'h000B_0006, "A_result2");
        bus_wr(A_STAT, 32'h0000_0003);
        bus_rd(A_STAT, 32'h0000_0010, "A_w1c");
        check_eq("A_irq", irq_cnt, 32'd2);
        bus_wr(A_CTRL, 32'h0000_0000);
        bus_rd(A_STAT, 32'h0000_0000, "A_dis_idle");
        bus_rd(A_RES,  32'h000B_0006, "A_dis_result_kept");
        pwm_i = 1'b0;
        cyc(2);

        // div=1: halves the tick rate
        irq_base = irq_cnt;
        bus_wr(A_CTRL, 32'h0001_0009);
        cyc(2);
        pwm_hl(3, 5);
        pwm_hl(3, 5);
        pwm_i = 1'b1; cyc(4);
        bus_rd(A_RES,  32'h0004_0001, "B_result_div1");
        bus_rd(A_STAT, 32'h0000_0013, "B_stat");
        check_eq("B_irq", irq_cnt - irq_base, 32'd2);
        bus_wr(A_CTRL, 32'h0000_0000);
        pwm_i = 1'b0;
        cyc(2);

        // Timeout with the active level held
        irq_base = irq_cnt;
        bus_wr(A_STAT, 32'h0000_0007);
        bus_wr(A_TMO,  32'h0000_000A);
        bus_wr(A_CTRL, 32'h0000_0009);
        pwm_i = 1'b1; cyc(20);
        bus_rd(A_STAT, 32'h0000_000C, "C_timeout");
        bus_rd(A_RES,  32'h0004_0001, "C_result_kept");
        bus_rd(A_TMO,  32'h0000_000A, "C_tmo_rw");
        cyc(1);
        check_eq("C_irq", irq_cnt - irq_base, 32'd1);
        bus_wr(A_CTRL, 32'h0000_0000);
        pwm_i = 1'b0;
        cyc(2);

        // Oneshot: later shorter periods must not produce a result
        irq_base = irq_cnt;
        bus_wr(A_STAT, 32'h0000_0007);
        bus_wr(A_CTRL, 32'h0000_000D);
        cyc(2);
        pwm_hl(3, 5);
        pwm_hl(2, 2);
        pwm_hl(2, 2);
        pwm_hl(2, 2);
        cyc(4);
        bus_rd(A_CTRL, 32'h0000_000C, "D_en_cleared");
        bus_rd(A_STAT, 32'h0000_0001, "D_stat_idle");
        bus_rd(A_RES,  32'h0008_0003, "D_result");
        cyc(1);
        check_eq("D_irq", irq_cnt - irq_base, 32'd1);

        // Asynchronous reset while in INACT
        irq_base = irq_cnt;
        bus_wr(A_STAT, 32'h0000_0007);
        bus_wr(A_TMO,  32'h0000_0020);
        bus_wr(A_CTRL, 32'h0000_0009);
        cyc(2);
        pwm_hl(3, 5);
        pwm_i = 1'b1; cyc(3);
        pwm_i = 1'b0; cyc(4);
        bus_rd(A_STAT, 32'h0000_0019, "E_inact");
        bus_rd(A_RES,  32'h0008_0003, "E_result");
        cyc(1);
        check_eq("E_irq_pre", irq_cnt - irq_base, 32'd1);
        irq_base = irq_cnt;
        #3 rst_n = 1'b0;
        #4 rst_n = 1'b1;
        cyc(1);
        check_eq("E_rst_dout", data_o, 32'h0000_0000);
        pwm_hl(3, 5);
        pwm_i = 1'b1; cyc(2);
        pwm_i = 1'b0; cyc(4);
        bus_rd(A_CTRL, 32'h0000_0000, "E_rst_ctrl");
        bus_rd(A_STAT, 32'h0000_0000, "E_rst_stat");
        bus_rd(A_RES,  32'h0000_0000, "E_rst_result");
        bus_rd(A_TMO,  32'h0000_FFFF, "E_rst_tmo");
        cyc(3);
        check_eq("E_irq_post", irq_cnt - irq_base, 32'd0);
        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
